div: RTL
========

Name: div

Overview:
Multi-cycle 32-bit integer divider for the EX stage. It serves the DIV/DIVU operands that EX receives from the ID/EX pipeline register. EX is the initiator: it asserts start_i with both operands and stalls the pipeline until ready_o. The 64-bit result is {remainder, quotient} and is written to HI/LO by EX.

Parameters:
DATA_W, 32, operand width; only 32 is supported.
ITER, 32, iterations per division; must equal DATA_W.

Ports:
clk  in  1  pipeline clock, rising edge.
rst  in  1  synchronous reset, active-high; the asserted level is `RstEnable.
signed_div_i  in  1  1 = DIV (signed), 0 = DIVU.
opdata1_i  in  32  dividend (ex_reg1 path).
opdata2_i  in  32  divisor (ex_reg2 path).
start_i  in  1  request; EX holds it high until it has consumed the result.
annul_i  in  1  abort the current division (branch-delay/flush); has priority over start_i.
result_o  out  64  [63:32] remainder (to HI), [31:0] quotient (to LO).
ready_o  out  1  result_o valid.

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high.
- Reset (rst == `RstEnable at a rising edge):
  - state = DIV_FREE, ready_o = 0, result_o = 0, counter = 0.
  - Applies mid-operation too; the in-flight division is discarded.
- Outputs: all registered; no combinational path from inputs to outputs.
- States: DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END.
- DIV_FREE:
  - start_i=1, annul_i=0, opdata2_i==0 -> DIV_BY_ZERO.
  - start_i=1, annul_i=0, opdata2_i!=0 -> DIV_ON:
    - latch signed_div_i;
    - latch the sign of each operand and its magnitude; for signed operation use the two's-complement absolute value, for unsigned use the raw operand;
    - counter = 0.
  - Otherwise stay; ready_o = 0, result_o = 0.
- DIV_BY_ZERO:
  - Unconditionally -> DIV_END with result_o = 0.
  - The MIPS result is UNPREDICTABLE; the team fixes it at 0.
- DIV_ON: one restoring iteration per cycle on a 65-bit working register {partial_remainder, quotient}.
  - Shift left by 1.
  - Trial subtract: partial_remainder minus divisor magnitude, 33-bit.
  - No borrow: keep the difference and set quotient LSB = 1; otherwise restore and set LSB = 0.
  - counter increments on each iteration.
  - When counter == 32 (the cycle after the 32nd iteration), apply sign correction:
    - quotient negated when signed and dividend sign != divisor sign;
    - remainder negated when signed and dividend is negative (remainder takes the dividend's sign).
  - The sign-corrected result is latched into result_o and state -> DIV_END.
  - annul_i=1 in DIV_ON -> DIV_FREE next edge; result_o = 0, ready_o = 0.
  - start_i dropping in DIV_ON without annul_i is ignored; the division completes.
- DIV_END:
  - ready_o = 1 and result_o is held stable.
  - start_i == 0 -> DIV_FREE with ready_o = 0 and result_o = 0 on that edge.
  - start_i held high -> stay in DIV_END; no new division starts until start_i has been low for at least one edge.
- Latency, start sampled at edge N:
  - nonzero divisor: ready_o high after edge N+33;
  - zero divisor: ready_o high after edge N+2.
- Operand changes after edge N have no effect.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (wraps, no trap).
- annul_i and start_i both high in DIV_FREE: no start.

Test Plan:
- DIVU 100 / 7, start held until ready -> ready_o rises exactly 33 edges after the start edge; result_o = 64'h00000002_0000000E; start_i low -> ready_o = 0 next edge.
- DIV -7 / 2 (0xFFFFFFF9, 0x00000002) -> result_o = 64'hFFFFFFFF_FFFFFFFD. DIV 7 / -2 -> 64'h00000001_FFFFFFFD.
- Divisor 0 (DIVU 0x1234 / 0) -> ready_o high after edge N+2, result_o = 0.
- Corner values:
  - DIV 0x80000000 / 0xFFFFFFFF -> 64'h00000000_80000000;
  - DIVU 0xFFFFFFFF / 1 -> 64'h00000000_FFFFFFFF.
- annul_i pulsed 10 edges into DIV_ON -> ready_o never rises, result_o = 0. A new DIVU 9 / 3 started the following cycle -> 64'h00000000_00000003 after 33 edges.
- rst asserted 5 edges into DIV_ON -> ready_o = 0 and result_o = 0 after that edge. A held start_i with 50 / 5 after rst deasserts -> full 33-edge latency, 64'h00000000_0000000A.

Source files
------------

// File: rtl/div.sv
// -----------------------------------------------------------------------------
// div -- multi-cycle 32-bit integer divider for the EX stage.
//
// EX raises start_i with both operands and stalls until ready_o. One restoring
// iteration runs per clock; the 64-bit result is {remainder, quotient} and is
// written to HI/LO by EX. A zero divisor produces a fixed all-zero result.
//
// Ports:
//   clk           pipeline clock, rising edge
//   rst           synchronous reset, active-high (`RstEnable)
//   signed_div_i  1 = DIV (signed), 0 = DIVU
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held high by EX until the result is consumed
//   annul_i       abort the current division; wins over start_i
//   result_o      [63:32] remainder (HI), [31:0] quotient (LO)
//   ready_o       result_o valid
// -----------------------------------------------------------------------------
`ifndef RstEnable
`define RstEnable 1'b1
`endif

module div #(
  parameter int DATA_W = 32,
  parameter int ITER   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam int              CNT_W     = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] ITER_DONE = CNT_W'(ITER);

  typedef enum logic [1:0] {
    DIV_FREE,
    DIV_BY_ZERO,
    DIV_ON,
    DIV_END
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    counter;
  logic [2*DATA_W:0]   work;       // {partial_remainder, quotient}
  logic [DATA_W-1:0]   dvs_mag;
  logic                signed_q;
  logic                dvd_neg;
  logic                dvs_neg;

  // Operand magnitudes, only meaningful on the start edge.
  logic                op1_neg;
  logic                op2_neg;
  logic [DATA_W-1:0]   op1_mag;
  logic [DATA_W-1:0]   op2_mag;

  // One restoring step and the final sign correction.
  logic [2*DATA_W:0]   shifted;
  logic [DATA_W+1:0]   trial;
  logic [2*DATA_W:0]   work_next;
  logic [DATA_W-1:0]   quot_fix;
  logic [DATA_W-1:0]   rem_fix;

  // NOTE: every signal driven in always_comb gets a default assignment first,
  // so no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    op1_neg   = signed_div_i & opdata1_i[DATA_W-1];
    op2_neg   = signed_div_i & opdata2_i[DATA_W-1];
    op1_mag   = op1_neg ? -opdata1_i : opdata1_i;
    op2_mag   = op2_neg ? -opdata2_i : opdata2_i;

    shifted   = work << 1;
    // 34-bit subtract so the MSB is the borrow of the 33-bit trial.
    trial     = {1'b0, shifted[2*DATA_W:DATA_W]} - {2'b00, dvs_mag};
    work_next = shifted;
    if (!trial[DATA_W+1]) begin
      work_next = {trial[DATA_W:0], shifted[DATA_W-1:1], 1'b1};
    end

    // Quotient is negative when signs differ; remainder follows the dividend.
    quot_fix  = (signed_q & (dvd_neg ^ dvs_neg)) ? -work[DATA_W-1:0]
                                                 :  work[DATA_W-1:0];
    rem_fix   = (signed_q & dvd_neg) ? -work[2*DATA_W-1:DATA_W]
                                     :  work[2*DATA_W-1:DATA_W];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst == `RstEnable) begin
      state    <= DIV_FREE;
      ready_o  <= 1'b0;
      result_o <= '0;
      counter  <= '0;
      work     <= '0;
      dvs_mag  <= '0;
      signed_q <= 1'b0;
      dvd_neg  <= 1'b0;
      dvs_neg  <= 1'b0;
    end else begin
      unique case (state)
        DIV_FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= DIV_BY_ZERO;
            end else begin
              state    <= DIV_ON;
              counter  <= '0;
              signed_q <= signed_div_i;
              dvd_neg  <= op1_neg;
              dvs_neg  <= op2_neg;
              dvs_mag  <= op2_mag;
              work     <= {{(DATA_W+1){1'b0}}, op1_mag};
            end
          end
        end

        DIV_BY_ZERO: begin
          state    <= DIV_END;
          ready_o  <= 1'b0;
          result_o <= '0;
        end

        DIV_ON: begin
          if (annul_i) begin
            state    <= DIV_FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else if (counter == ITER_DONE) begin
            state    <= DIV_END;
            ready_o  <= 1'b1;
            result_o <= {rem_fix, quot_fix};
            counter  <= '0;
          end else begin
            work    <= work_next;
            counter <= counter + CNT_W'(1);
          end
        end

        DIV_END: begin
          // Holding start_i parks here, so a new request needs a low edge first.
          if (!start_i) begin
            state    <= DIV_FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else begin
            ready_o <= 1'b1;
          end
        end

        default: state <= DIV_FREE;
      endcase
    end
  end

endmodule
